// File: rtl/i2c_dac_pkg.sv
// Shared types and defaults for the I2C DAC target.
// Holds the FSM state enum, default address/command constants and helpers.
package i2c_dac_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_CMD,
        S_CMD_ACK,
        S_DHI,
        S_DHI_ACK,
        S_DLO,
        S_DLO_ACK,
        S_WAIT_STOP
    } state_t;

    localparam logic [5:0] ADDR_HI_DEF   = 6'b100110;
    localparam logic [3:0] CMD_WRITE_DEF = 4'b0011;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Frame was addressed to us but ended before the write completed.
    function automatic logic mid_frame(input state_t s);
        return (s == S_ADDR_ACK) || (s == S_CMD) || (s == S_CMD_ACK) ||
               (s == S_DHI) || (s == S_DHI_ACK) || (s == S_DLO);
    endfunction

    // States in which SCL rising edges shift a bit in.
    function automatic logic rx_state(input state_t s);
        return (s == S_ADDR) || (s == S_CMD) || (s == S_DHI) ||
               (s == S_DLO) || (s == S_WAIT_STOP);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk_in and detects bus edges and conditions.
// Ports: scl_in/sda_in async lines; sda_sync, scl_rise/fall, start/stop_det.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_sync,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // Top bit of each chain is the previous synchronized value.
    logic [SYNC_STAGES:0] scl_q;
    logic [SYNC_STAGES:0] sda_q;
    logic scl_s, scl_p, sda_p;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-1:0], scl_in};
            sda_q <= {sda_q[SYNC_STAGES-1:0], sda_in};
        end
    end

    assign scl_s    = scl_q[SYNC_STAGES-1];
    assign scl_p    = scl_q[SYNC_STAGES];
    assign sda_sync = sda_q[SYNC_STAGES-1];
    assign sda_p    = sda_q[SYNC_STAGES];

    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & scl_p & sda_p & ~sda_sync;
    assign stop_det  = scl_s & scl_p & ~sda_p & sda_sync;

endmodule

// File: rtl/i2c_dac_target.sv
// I2C write-only target receiving 12-bit DAC codes for 16 channels.
// Ports: scl_in/sda_in bus, sda_oe pull-down, wr_* write strobe, busy, err_cnt.
module i2c_dac_target
    import i2c_dac_pkg::*;
#(
    parameter logic [5:0] ADDR_HI     = ADDR_HI_DEF,
    parameter logic [3:0] CMD_WRITE   = CMD_WRITE_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic        chip_id,
    output logic        wr_valid,
    output logic [3:0]  wr_chan,
    output logic [11:0] wr_data,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    logic sda_sync, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_sync (sda_sync),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_t     state_q;
    logic [2:0] bit_q;
    logic       done_q;
    logic       extra_q;
    logic [7:0] sh_q;
    logic [3:0] chan_q;
    logic [7:0] hi_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= S_IDLE;
            bit_q    <= '0;
            done_q   <= 1'b0;
            extra_q  <= 1'b0;
            sh_q     <= '0;
            chan_q   <= '0;
            hi_q     <= '0;
            sda_oe   <= 1'b0;
            wr_valid <= 1'b0;
            wr_chan  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            err_cnt  <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                if (mid_frame(state_q)) err_cnt <= sat_inc(err_cnt);
                state_q <= S_ADDR;
                bit_q   <= '0;
                done_q  <= 1'b0;
                extra_q <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop_det) begin
                if (mid_frame(state_q)) err_cnt <= sat_inc(err_cnt);
                state_q <= S_IDLE;
                bit_q   <= '0;
                done_q  <= 1'b0;
                extra_q <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                if (scl_rise && rx_state(state_q) && !done_q) begin
                    sh_q  <= {sh_q[6:0], sda_sync};
                    bit_q <= bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        done_q <= 1'b1;
                        // Low nibble of the code is the top of this byte.
                        if (state_q == S_DLO) begin
                            wr_valid <= 1'b1;
                            wr_chan  <= chan_q;
                            wr_data  <= {hi_q, sh_q[6:3]};
                        end
                        if (state_q == S_WAIT_STOP && extra_q) begin
                            err_cnt <= sat_inc(err_cnt);
                            extra_q <= 1'b0;
                        end
                    end
                end
                if (scl_fall) begin
                    unique case (state_q)
                        S_ADDR: if (done_q) begin
                            done_q <= 1'b0;
                            if (sh_q == {ADDR_HI, chip_id, 1'b0}) begin
                                state_q <= S_ADDR_ACK;
                                sda_oe  <= 1'b1;
                            end else begin
                                state_q <= S_WAIT_STOP;
                            end
                        end
                        S_CMD: if (done_q) begin
                            done_q <= 1'b0;
                            if (sh_q[7:4] == CMD_WRITE) begin
                                chan_q  <= sh_q[3:0];
                                state_q <= S_CMD_ACK;
                                sda_oe  <= 1'b1;
                            end else begin
                                err_cnt <= sat_inc(err_cnt);
                                state_q <= S_WAIT_STOP;
                            end
                        end
                        S_DHI: if (done_q) begin
                            done_q  <= 1'b0;
                            hi_q    <= sh_q;
                            state_q <= S_DHI_ACK;
                            sda_oe  <= 1'b1;
                        end
                        S_DLO: if (done_q) begin
                            done_q  <= 1'b0;
                            state_q <= S_DLO_ACK;
                            sda_oe  <= 1'b1;
                        end
                        S_ADDR_ACK: begin
                            sda_oe  <= 1'b0;
                            state_q <= S_CMD;
                        end
                        S_CMD_ACK: begin
                            sda_oe  <= 1'b0;
                            state_q <= S_DHI;
                        end
                        S_DHI_ACK: begin
                            sda_oe  <= 1'b0;
                            state_q <= S_DLO;
                        end
                        S_DLO_ACK: begin
                            sda_oe  <= 1'b0;
                            extra_q <= 1'b1;
                            state_q <= S_WAIT_STOP;
                        end
                        S_IDLE, S_WAIT_STOP: ;
                        default: begin
                            sda_oe  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_dac_target.sv
// Scoreboard bench for i2c_dac_target: directed I2C frames, write monitor.
// Ports: drives scl/sda (open-drain model), chip_id, reset; checks outputs.
module tb_i2c_dac_target;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        scl_in = 1'b1;
    logic        sda_drv = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic        chip_id = 1'b0;
    logic        wr_valid;
    logic [3:0]  wr_chan;
    logic [11:0] wr_data;
    logic        busy;
    logic [7:0]  err_cnt;

    int checks = 0;
    int failures = 0;
    int nwr = 0;
    logic prev_wv = 1'b0;
    logic [15:0] sb[$];

    assign sda_line = sda_drv & ~sda_oe;

    always #5 clk_in = ~clk_in;

    i2c_dac_target dut (
        .clk_in  (clk_in),
        .reset_in(reset_in),
        .scl_in  (scl_in),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .chip_id (chip_id),
        .wr_valid(wr_valid),
        .wr_chan (wr_chan),
        .wr_data (wr_data),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every wr_valid pops one expected {chan, data}.
    always @(negedge clk_in) begin
        logic [15:0] e;
        if (reset_in && wr_valid) begin
            chk("wv_pulse", 32'(prev_wv), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected got chan=%0h data=%0h required none",
                         wr_chan, wr_data);
            end else begin
                e = sb.pop_front();
                chk("wr_chan", 32'(wr_chan), 32'(e[15:12]));
                chk("wr_data", 32'(wr_data), 32'(e[11:0]));
                nwr++;
            end
        end
        prev_wv = wr_valid;
    end

    task automatic q();
        repeat (4) @(posedge clk_in);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; q();
        scl_in  = 1'b1; q();
        sda_drv = 1'b0; q();
        scl_in  = 1'b0; q();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; q();
        scl_in  = 1'b1; q();
        sda_drv = 1'b1; q();
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; q();
        scl_in  = 1'b1; q(); q();
        scl_in  = 1'b0; q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input string name, input logic [7:0] b,
                             input logic exp_ack);
        send_bits(b, 8);
        sda_drv = 1'b1; q();
        scl_in  = 1'b1; q();
        #1 chk({name, "_ack"}, 32'(sda_oe), 32'(exp_ack));
        q();
        scl_in  = 1'b0; q();
        #1 chk({name, "_rel"}, 32'(sda_oe), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_oe", 32'(sda_oe), 0);
        chk("rst_wv", 32'(wr_valid), 0);
        chk("rst_chan", 32'(wr_chan), 0);
        chk("rst_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_cnt), 0);
        reset_in = 1'b1;
        q();

        // Full write to chip 0x4C: chan 5, code 0xABC.
        bus_start();
        chk("t1_busy", 32'(busy), 1);
        sb.push_back({4'h5, 12'hABC});
        send_byte("t1_addr", 8'h98, 1'b1);
        send_byte("t1_cmd", 8'h35, 1'b1);
        send_byte("t1_dhi", 8'hAB, 1'b1);
        send_byte("t1_dlo", 8'hC0, 1'b1);
        bus_stop();
        q();
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_chan", 32'(wr_chan), 5);
        chk("t1_data", 32'(wr_data), 32'hABC);
        chk("t1_err", 32'(err_cnt), 0);

        // Chip 1 does not answer 0x4C; no error counted.
        chip_id = 1'b1;
        bus_start();
        send_byte("t2_addr", 8'h98, 1'b0);
        send_byte("t2_cmd", 8'h35, 1'b0);
        chk("t2_busy", 32'(busy), 1);
        bus_stop();
        q();
        chk("t2_busy_end", 32'(busy), 0);
        chk("t2_err", 32'(err_cnt), 0);
        chip_id = 1'b0;

        // Bad command nibble.
        bus_start();
        send_byte("t3_addr", 8'h98, 1'b1);
        send_byte("t3_cmd", 8'h15, 1'b0);
        send_byte("t3_dhi", 8'hAB, 1'b0);
        bus_stop();
        q();
        chk("t3_err", 32'(err_cnt), 1);
        chk("t3_data", 32'(wr_data), 32'hABC);

        // Abort in DHI by STOP: no write, counted as aborted frame.
        bus_start();
        send_byte("t4a_addr", 8'h98, 1'b1);
        send_byte("t4a_cmd", 8'h3F, 1'b1);
        send_bits(8'hA0, 3);
        bus_stop();
        q();
        chk("t4a_err", 32'(err_cnt), 2);
        chk("t4a_data", 32'(wr_data), 32'hABC);

        // Abort in DLO by repeated START, then full write chan F code 0.
        bus_start();
        send_byte("t4b_addr", 8'h98, 1'b1);
        send_byte("t4b_cmd", 8'h3F, 1'b1);
        send_byte("t4b_dhi", 8'h12, 1'b1);
        bus_start();
        chk("t4b_err", 32'(err_cnt), 3);
        sb.push_back({4'hF, 12'h000});
        send_byte("t4c_addr", 8'h98, 1'b1);
        send_byte("t4c_cmd", 8'h3F, 1'b1);
        send_byte("t4c_dhi", 8'h00, 1'b1);
        send_byte("t4c_dlo", 8'h00, 1'b1);
        bus_stop();
        q();
        chk("t4c_chan", 32'(wr_chan), 32'hF);
        chk("t4c_data", 32'(wr_data), 0);
        chk("t4c_err", 32'(err_cnt), 3);

        // Extra bytes after a complete write: one error per frame.
        bus_start();
        sb.push_back({4'h2, 12'h123});
        send_byte("t5_addr", 8'h98, 1'b1);
        send_byte("t5_cmd", 8'h32, 1'b1);
        send_byte("t5_dhi", 8'h12, 1'b1);
        send_byte("t5_dlo", 8'h34, 1'b1);
        send_byte("t5_x1", 8'h55, 1'b0);
        chk("t5_err1", 32'(err_cnt), 4);
        send_byte("t5_x2", 8'h66, 1'b0);
        bus_stop();
        q();
        chk("t5_err2", 32'(err_cnt), 4);
        chk("t5_chan", 32'(wr_chan), 2);
        chk("t5_data", 32'(wr_data), 32'h123);

        // Reset while acknowledging the high data byte.
        bus_start();
        send_byte("t6_addr", 8'h98, 1'b1);
        send_byte("t6_cmd", 8'h35, 1'b1);
        send_bits(8'hAB, 8);
        #1 chk("t6_oe_pre", 32'(sda_oe), 1);
        reset_in = 1'b0;
        #1;
        chk("t6_oe", 32'(sda_oe), 0);
        chk("t6_wv", 32'(wr_valid), 0);
        chk("t6_chan", 32'(wr_chan), 0);
        chk("t6_data", 32'(wr_data), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_err", 32'(err_cnt), 0);
        sda_drv = 1'b1;
        scl_in  = 1'b1;
        q();
        reset_in = 1'b1;
        q(); q();

        chk("sb_empty", 32'(sb.size()), 0);
        chk("wr_count", 32'(nwr), 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_dac_target.md
I2C_DAC_TARGET -- requirements
Module: i2c_dac_target

Interface
REQ-001 SHALL have parameter ADDR_HI, default 6'b100110: upper six bits of the 7-bit target address.
REQ-002 SHALL have parameter CMD_WRITE, default 4'b0011: only accepted command nibble.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on scl_in/sda_in.
REQ-004 SHALL have port clk_in, input, 1: system clock; reset reset_in, asynchronous, active-low; clock clk_in.
REQ-005 SHALL have port reset_in, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port scl_in, input, 1: bus clock line, asynchronous to clk_in.
REQ-007 SHALL have port sda_in, input, 1: bus data line, asynchronous to clk_in.
REQ-008 SHALL have port sda_oe, output, 1: 1 means pull SDA low (open-drain); never drive high.
REQ-009 SHALL have port chip_id, input, 1: address LSB; target address = {ADDR_HI, chip_id}.
REQ-010 SHALL have port wr_valid, output, 1: one-cycle strobe for a completed channel write.
REQ-011 SHALL have port wr_chan, output, 4: channel of the last completed write.
REQ-012 SHALL have port wr_data, output, 12: voltage code of the last completed write.
REQ-013 SHALL have port busy, output, 1: high from START detection until STOP detection.
REQ-014 SHALL have port err_cnt, output, 8: saturating count of NACKed bytes and aborted frames.

Function
REQ-015 Frame: S, addr[6:0]+W, ACK, cmd{CMD_WRITE, chan[3:0]}, ACK, vol[11:4], ACK, {vol[3:0], 4'bxxxx}, ACK, P; all fields MSB first.
REQ-016 SDA SHALL be sampled on synchronized SCL rising edge; START = SDA fall while SCL high; STOP = SDA rise while SCL high.
REQ-017 FSM states: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, DHI, DHI_ACK, DLO, DLO_ACK, WAIT_STOP.
REQ-018 START from any state SHALL go to ADDR with bit counter cleared (repeated start supported).
REQ-019 STOP from any state SHALL go to IDLE; any partial frame SHALL be discarded without wr_valid.
REQ-020 Address mismatch or R/W=1 SHALL NACK (sda_oe stays 0) and go to WAIT_STOP, with no err_cnt increment.
REQ-021 cmd[7:4] != CMD_WRITE SHALL NACK, increment err_cnt, go to WAIT_STOP.
REQ-022 ACK: sda_oe SHALL assert in the clk_in cycle after the SCL falling edge ending bit 8, and deassert after the next SCL falling edge.
REQ-023 wr_valid SHALL pulse exactly one cycle, 1 cycle after the 8th DLO bit is sampled; wr_chan/wr_data SHALL update in the same cycle and hold until the next write.
REQ-024 Any byte after DLO_ACK before STOP SHALL be NACKed, increment err_cnt once per frame, and go to WAIT_STOP.
REQ-025 err_cnt SHALL saturate at 8'hFF.
REQ-026 Bus timing SHALL be met for SCL period >= 8 clk_in cycles; edge-detect latency = SYNC_STAGES+1 cycles.
REQ-027 sda_oe SHALL be 0 in every state other than ADDR_ACK, CMD_ACK, DHI_ACK, DLO_ACK.

Reset
REQ-028 On reset_in low: state IDLE, sda_oe=0, wr_valid=0, wr_chan=0, wr_data=0, busy=0, err_cnt=0, synchronizers=1 (bus idle).
REQ-029 Reset mid-frame SHALL release SDA immediately (asynchronously) and no write SHALL occur.

Structure
REQ-030 Package i2c_dac_pkg SHALL hold the FSM state enum and default ADDR_HI/CMD_WRITE constants.
REQ-031 Sub-module i2c_line_sync SHALL synchronize scl_in/sda_in and output scl_rise, scl_fall, start_det, stop_det.

Verification
REQ-032 chip_id=0, frame addr 0x4C W, cmd 0x35, 0xAB, 0xC0, P -> four ACKs, wr_valid once, wr_chan=5, wr_data=12'hABC.
REQ-033 chip_id=1, addr 0x4C -> addr NACK, no wr_valid, err_cnt=0, busy falls on STOP.
REQ-034 cmd 0x15 -> CMD NACK, err_cnt=1, no write.
REQ-035 Valid frame to DHI then STOP -> no wr_valid; then repeated START + full write chan 0xF data 0x000 -> wr_chan=15, wr_data=0.
REQ-036 Fifth byte 0x55 after DLO ACK -> NACK, err_cnt+1, prior write retained.
REQ-037 reset_in low during DHI_ACK -> sda_oe=0 same cycle, all outputs at reset values.
